// File: rtl/wieg_aandrijving.sv
// rtl/wieg_aandrijving.sv - cradle drive: triangular rocking trajectory from A/F codes with error return
module wieg_aandrijving #(
  parameter int TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        A,
  input  logic [2:0]        F,
  input  logic              err,
  output logic signed [7:0] pos,
  output logic              stap,
  output logic              richting,
  output logic              inMidden,
  output logic              actief
);

  // Divider wide enough for the slowest setting (F = 1 -> 7*TICK_DIV cycles).
  localparam int DW = (7 * TICK_DIV > 1) ? $clog2(7 * TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWING  = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DW-1:0]     div, div_n;
  logic [2:0]        act_a, act_a_n;
  logic [2:0]        act_f, act_f_n;
  logic signed [7:0] pos_n;
  logic              stap_n;
  logic              richting_n;

  logic [DW-1:0]     last_cnt;
  logic              step;
  logic signed [7:0] peak;
  logic signed [7:0] neg_peak;
  logic signed [7:0] moved;

  // Step interval and peak derive only from the latched settings, never from live inputs.
  assign last_cnt = DW'(TICK_DIV * (8 - int'(act_f)) - 1);
  assign step     = (div == last_cnt);
  assign peak     = {1'b0, act_a, 4'b0000};
  assign neg_peak = -peak;
  assign moved    = richting ? (pos + 8'sd1) : (pos - 8'sd1);
  assign actief   = (state != ST_IDLE);

  // Next-state and datapath decisions; err outranks the divider in SWING.
  always_comb begin
    state_n    = state;
    div_n      = div;
    act_a_n    = act_a;
    act_f_n    = act_f;
    pos_n      = pos;
    stap_n     = 1'b0;
    richting_n = richting;
    case (state)
      ST_IDLE: begin
        div_n = '0;
        pos_n = 8'sd0;
        if (A != 3'd0 && F != 3'd0 && !err) begin
          act_a_n    = A;
          act_f_n    = F;
          richting_n = 1'b1;
          state_n    = ST_SWING;
        end
      end
      ST_SWING: begin
        if (err) begin
          div_n = '0;
          if (pos != 8'sd0) begin
            richting_n = pos[7];
            state_n    = ST_RETURN;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (step) begin
          div_n  = '0;
          pos_n  = moved;
          stap_n = 1'b1;
          if (moved == peak) begin
            richting_n = 1'b0;
          end else if (moved == neg_peak) begin
            richting_n = 1'b1;
          end
          // Centre crossing is the only point where new settings take effect.
          if (moved == 8'sd0) begin
            act_a_n = A;
            act_f_n = F;
            if (A == 3'd0 || F == 3'd0) begin
              state_n = ST_IDLE;
            end
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      ST_RETURN: begin
        if (step) begin
          div_n  = '0;
          pos_n  = moved;
          stap_n = 1'b1;
          if (moved == 8'sd0) begin
            state_n = ST_IDLE;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        div_n   = '0;
        pos_n   = 8'sd0;
      end
    endcase
  end

  // State and datapath registers; inMidden is registered from the same next position as pos.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      div      <= '0;
      act_a    <= 3'd0;
      act_f    <= 3'd0;
      pos      <= 8'sd0;
      stap     <= 1'b0;
      richting <= 1'b1;
      inMidden <= 1'b1;
    end else begin
      state    <= state_n;
      div      <= div_n;
      act_a    <= act_a_n;
      act_f    <= act_f_n;
      pos      <= pos_n;
      stap     <= stap_n;
      richting <= richting_n;
      inMidden <= (pos_n == 8'sd0);
    end
  end

endmodule

// File: tb/tb_wieg_aandrijving.sv
// tb/tb_wieg_aandrijving.sv - directed self-checking bench for wieg_aandrijving
module tb_wieg_aandrijving;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        A;
  logic [2:0]        F;
  logic              err;
  logic signed [7:0] pos;
  logic              stap;
  logic              richting;
  logic              inMidden;
  logic              actief;

  int n_tests = 0;
  int n_fail  = 0;

  wieg_aandrijving #(.TICK_DIV(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .F        (F),
    .err      (err),
    .pos      (pos),
    .stap     (stap),
    .richting (richting),
    .inMidden (inMidden),
    .actief   (actief)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until a step lands pos on target; the cycle count is checked against exp (timeout shows as mismatch).
  task automatic run_until(input string tag, input int target, input int exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(stap && int'(pos) == target) && n < exp + 50);
    check_eq(tag, n, exp);
  endtask

  initial begin
    int cnt;
    reset = 1'b0; A = 3'd0; F = 3'd0; err = 1'b0;
    tick(); tick();
    check_eq("rst_pos", int'(pos), 0);
    check_eq("rst_stap", int'(stap), 0);
    check_eq("rst_richting", int'(richting), 1);
    check_eq("rst_inmidden", int'(inMidden), 1);
    check_eq("rst_actief", int'(actief), 0);

    // Basic swing, A=1 F=7 -> peak 16, interval 2
    reset = 1'b1; A = 3'd1; F = 3'd7;
    tick();
    check_eq("start_actief", int'(actief), 1);
    check_eq("start_pos", int'(pos), 0);
    run_until("first_step_lat", 1, 2);
    run_until("to_peak16", 16, 30);
    check_eq("peak16_richting", int'(richting), 0);
    run_until("to_neg16", -16, 64);
    check_eq("neg16_richting", int'(richting), 1);
    run_until("period_rest", 1, 34);

    // Amplitude change mid-swing takes effect only after next centre landing
    run_until("to_pos9", 9, 16);
    A = 3'd3;
    run_until("old_peak16", 16, 14);
    check_eq("old_peak_richting", int'(richting), 0);
    run_until("down_to0", 0, 32);
    run_until("past_neg16", -16, 32);
    check_eq("no_turn_at_neg16", int'(richting), 0);
    run_until("to_neg48", -48, 64);
    check_eq("neg48_richting", int'(richting), 1);
    run_until("up_to12", 12, 120);

    // Error pulse at pos=12 rising
    check_eq("pre_err_richting", int'(richting), 1);
    err = 1'b1;
    tick();
    err = 1'b0;
    check_eq("ret_actief", int'(actief), 1);
    check_eq("ret_richting", int'(richting), 0);
    check_eq("ret_pos_hold", int'(pos), 12);
    check_eq("ret_no_stap", int'(stap), 0);
    run_until("ret_to0", 0, 24);
    check_eq("ret_idle_actief", int'(actief), 0);
    check_eq("ret_idle_inmidden", int'(inMidden), 1);
    tick();
    check_eq("restart_actief", int'(actief), 1);

    // Stop via F=0 while swinging (A=3 -> peak 48)
    run_until("stop_to5", 5, 10);
    F = 3'd0;
    run_until("stop_to48", 48, 86);
    run_until("stop_to0", 0, 96);
    check_eq("stop_actief", int'(actief), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (stap) cnt++;
    end
    check_eq("stop_no_steps", cnt, 0);
    check_eq("stop_pos_hold", int'(pos), 0);

    // Reset mid-operation at pos=-30 (A=2 -> peak 32)
    A = 3'd2; F = 3'd7;
    tick();
    check_eq("a2_actief", int'(actief), 1);
    run_until("a2_to_neg30", -30, 188);
    reset = 1'b0;
    tick();
    check_eq("mid_rst_pos", int'(pos), 0);
    check_eq("mid_rst_actief", int'(actief), 0);
    check_eq("mid_rst_richting", int'(richting), 1);
    check_eq("mid_rst_inmidden", int'(inMidden), 1);
    reset = 1'b1;
    tick();
    check_eq("rerun_actief", int'(actief), 1);
    run_until("rerun_first_step", 1, 2);

    // Hold in error from IDLE
    reset = 1'b0;
    tick();
    reset = 1'b1; err = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (stap) cnt++;
    end
    check_eq("hold_no_steps", cnt, 0);
    check_eq("hold_actief", int'(actief), 0);
    err = 1'b0;
    tick();
    check_eq("hold_release_actief", int'(actief), 1);
    run_until("hold_release_step", 1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
